// File: rtl/cpu_pkg.sv
// Shared CPU core types for the writeback path.
// Holds the datapath width, register count, register address type
// and the writeback request record passed from producers to the register file.
package cpu_pkg;

  localparam int XW    = 32;
  localparam int NREGS = 32;

  typedef logic [4:0] regaddr_t;

  typedef struct packed {
    regaddr_t        rd;
    logic [XW-1:0]   data;
  } wb_req_t;

  // One-hot decode of a register address into a scoreboard-wide mask.
  function automatic logic [NREGS-1:0] reg_onehot(input regaddr_t r);
    logic [NREGS-1:0] one;
    one = {{(NREGS-1){1'b0}}, 1'b1};
    return one << r;
  endfunction

endpackage

// File: rtl/wb_scoreboard_if.sv
// Bundle of issue-check, result-producer and register-file-write signals.
// The slave side is the writeback/scoreboard unit; the master side drives
// issue traffic and results and observes the write port and scoreboard.
interface wb_scoreboard_if;
  import cpu_pkg::*;

  // issue side
  logic             issue_vld_ip;
  regaddr_t         issue_rd_ip;
  regaddr_t         chk_rs1_ip;
  regaddr_t         chk_rs2_ip;
  regaddr_t         chk_rd_ip;
  logic             stall_op;

  // ALU result stream (valid/ready)
  logic             alu_vld_ip;
  logic             alu_rdy_op;
  regaddr_t         alu_rd_ip;
  logic [XW-1:0]    alu_data_ip;

  // load result stream (always accepted)
  logic             lsu_vld_ip;
  regaddr_t         lsu_rd_ip;
  logic [XW-1:0]    lsu_data_ip;

  // register file write port and status
  logic             wr_en_op;
  regaddr_t         wr_addr_op;
  logic [XW-1:0]    wr_data_op;
  logic [NREGS-1:0] busy_op;
  logic             err_op;

  modport master (
    output issue_vld_ip, issue_rd_ip, chk_rs1_ip, chk_rs2_ip, chk_rd_ip,
    output alu_vld_ip, alu_rd_ip, alu_data_ip,
    output lsu_vld_ip, lsu_rd_ip, lsu_data_ip,
    input  stall_op, alu_rdy_op, wr_en_op, wr_addr_op, wr_data_op, busy_op, err_op
  );

  modport slave (
    input  issue_vld_ip, issue_rd_ip, chk_rs1_ip, chk_rs2_ip, chk_rd_ip,
    input  alu_vld_ip, alu_rd_ip, alu_data_ip,
    input  lsu_vld_ip, lsu_rd_ip, lsu_data_ip,
    output stall_op, alu_rdy_op, wr_en_op, wr_addr_op, wr_data_op, busy_op, err_op
  );

endinterface

// File: rtl/wb_skid.sv
// One-entry hold buffer for an ALU result displaced by a load.
// Latency: loaded entry is visible the cycle after load, cleared the cycle after drain.
// Backpressure: the owner must not load while full; load takes precedence over drain.
module wb_skid
  import cpu_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    load,
  input  logic    drain,
  input  wb_req_t d,
  output logic    vld,
  output wb_req_t q
);

  // Occupancy flag: set on load, cleared on drain or reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= 1'b0;
    end else if (load) begin
      vld <= 1'b1;
    end else if (drain) begin
      vld <= 1'b0;
    end
  end

  // Payload capture; only meaningful while vld is set.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/wb_scoreboard.sv
// Writeback arbiter (LSU > held ALU > new ALU) feeding a registered regfile write port, plus busy scoreboard.
// Latency: selected result appears on wr_* one cycle later; displaced ALU result at least two cycles later.
// Backpressure: ALU sees alu_rdy_op low while the hold entry is occupied; LSU is never stalled.
module wb_scoreboard #(
  parameter int XW = cpu_pkg::XW
) (
  input logic            clk,
  input logic            rst,
  wb_scoreboard_if.slave bus
);
  import cpu_pkg::*;

  // hold buffer
  logic     hold_vld;
  wb_req_t  hold_req;
  logic     hold_load;
  logic     hold_drain;

  // arbitration
  wb_req_t  alu_req;
  wb_req_t  lsu_req;
  wb_req_t  sel_req;
  logic     sel_vld;
  logic     alu_acc;

  // write port register
  logic          wr_en_q;
  regaddr_t      wr_addr_q;
  logic [XW-1:0] wr_data_q;

  // scoreboard and error
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_nxt;
  logic [NREGS-1:0] busy_set;
  logic [NREGS-1:0] busy_clr;
  logic             err_q;
  logic             err_nxt;

  assign alu_req = '{rd: bus.alu_rd_ip, data: bus.alu_data_ip};
  assign lsu_req = '{rd: bus.lsu_rd_ip, data: bus.lsu_data_ip};

  // A new ALU result is only taken when there is nowhere it could be stranded.
  assign bus.alu_rdy_op = ~hold_vld;
  assign alu_acc        = bus.alu_vld_ip & ~hold_vld;

  // Fixed-priority pick; an ALU result that loses to a load parks in the hold.
  always_comb begin
    sel_req    = alu_req;
    sel_vld    = 1'b0;
    hold_load  = 1'b0;
    hold_drain = 1'b0;
    if (bus.lsu_vld_ip) begin
      sel_req   = lsu_req;
      sel_vld   = 1'b1;
      hold_load = alu_acc;
    end else if (hold_vld) begin
      sel_req    = hold_req;
      sel_vld    = 1'b1;
      hold_drain = 1'b1;
    end else if (alu_acc) begin
      sel_req = alu_req;
      sel_vld = 1'b1;
    end
  end

  wb_skid u_skid (
    .clk   (clk),
    .rst   (rst),
    .load  (hold_load),
    .drain (hold_drain),
    .d     (alu_req),
    .vld   (hold_vld),
    .q     (hold_req)
  );

  // Register the selected request onto the write port; x0 writes are consumed silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q <= sel_vld & (sel_req.rd != '0);
      if (sel_vld) begin
        wr_addr_q <= sel_req.rd;
        wr_data_q <= sel_req.data;
      end
    end
  end

  // Next scoreboard: clear on commit, then set on issue so a same-cycle reissue stays busy.
  always_comb begin
    busy_set = '0;
    busy_clr = '0;
    if (bus.issue_vld_ip && (bus.issue_rd_ip != '0)) begin
      busy_set = reg_onehot(bus.issue_rd_ip);
    end
    if (wr_en_q) begin
      busy_clr = reg_onehot(wr_addr_q);
    end
    busy_nxt    = (busy_q & ~busy_clr) | busy_set;
    busy_nxt[0] = 1'b0;
  end

  // Sticky protocol error: double issue to a busy register or an unexpected writeback.
  always_comb begin
    err_nxt = err_q;
    if (bus.issue_vld_ip && busy_q[bus.issue_rd_ip]) begin
      err_nxt = 1'b1;
    end
    if (sel_vld && (sel_req.rd != '0) && !busy_q[sel_req.rd]) begin
      err_nxt = 1'b1;
    end
  end

  // Scoreboard and error state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
      err_q  <= 1'b0;
    end else begin
      busy_q <= busy_nxt;
      err_q  <= err_nxt;
    end
  end

  // Reads in issue see the register file only after the commit edge, so stall on busy state.
  assign bus.stall_op = busy_q[bus.chk_rs1_ip] | busy_q[bus.chk_rs2_ip] | busy_q[bus.chk_rd_ip];

  assign bus.wr_en_op   = wr_en_q;
  assign bus.wr_addr_op = wr_addr_q;
  assign bus.wr_data_op = wr_data_q;
  assign bus.busy_op    = busy_q;
  assign bus.err_op     = err_q;

endmodule
